prescaled_counter: RTL and testbench

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/prescaled_counter_pkg.sv | 18 +
 rtl/prescaled_counter_if.sv | 27 ++
 rtl/prescaled_counter_tick_gen.sv | 43 ++++
 rtl/prescaled_counter.sv | 80 ++++++++
 tb/tb_prescaled_counter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/prescaled_counter_pkg.sv
// Shared defaults, direction encoding and width helper for the prescaled counter.
package counter_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MODULUS  = 16;
    localparam int DEF_PRESCALE = 50_000_000;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prescaled_counter_if.sv
// Control/status bundle of the prescaled counter; master drives controls, slave returns count.
interface prescaled_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             en;
    logic             dir;
    logic             set;
    logic             clr;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;

    modport master (
        output en, dir, set, clr, init,
        input  count, tick, wrap
    );

    modport slave (
        input  en, dir, set, clr, init,
        output count, tick, wrap
    );

endinterface

// File: rtl/prescaled_counter_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the expiry edge.
module tick_gen
    import counter_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic expire
);

    localparam int            PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "tick_gen: PRESCALE must be >= 1");
    end

    logic [PW-1:0] cnt_q, cnt_d;

    assign expire = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || expire) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Modulo-MODULUS up/down counter stepping once per PRESCALE enabled clocks,
// with synchronous clear/load and registered tick/wrap pulses.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                reset,
    prescaled_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH < 1 || WIDTH > 30 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $fatal(1, "prescaled_counter: MODULUS must lie in 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "prescaled_counter: PRESCALE must be >= 1");
    end

    logic             expire;
    logic             restart;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    // Clear/load restart the prescaler; their priority below also drops any coincident step.
    assign restart = bus.clr || bus.set;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en),
        .restart (restart),
        .expire  (expire)
    );

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.set) begin
            count_d = (bus.init > MAX) ? MAX : bus.init;
        end else if (expire) begin
            tick_d = 1'b1;
            if (bus.dir == DIR_UP) begin
                wrap_d  = (count_q == MAX);
                count_d = (count_q == MAX) ? '0 : count_q + ONE;
            end else begin
                wrap_d  = (count_q == '0);
                count_d = (count_q == '0) ? MAX : count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: MODULUS=10 with PRESCALE=4 and PRESCALE=1 instances
// sharing one stimulus stream, checked against vectors and an arithmetic model.
`timescale 1ns/1ps
module tb_prescaled_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, dir, set, clr;
    logic [3:0] init;

    int checks = 0;
    int errors = 0;

    prescaled_counter_if #(.WIDTH(4)) bus_p4 ();
    prescaled_counter_if #(.WIDTH(4)) bus_p1 ();

    assign bus_p4.en = en;   assign bus_p1.en = en;
    assign bus_p4.dir = dir; assign bus_p1.dir = dir;
    assign bus_p4.set = set; assign bus_p1.set = set;
    assign bus_p4.clr = clr; assign bus_p1.clr = clr;
    assign bus_p4.init = init; assign bus_p1.init = init;

    prescaled_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut_p4 (
        .clk (clk), .reset (reset), .bus (bus_p4)
    );
    prescaled_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_p1 (
        .clk (clk), .reset (reset), .bus (bus_p1)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: per-instance count/phase as plain integers.
    int m_cnt[2], m_ph[2], m_tick[2], m_wrap[2];

    function automatic int pres(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ph[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        int raw;
        m_tick[k] = 0;
        m_wrap[k] = 0;
        if (clr) begin
            m_cnt[k] = 0; m_ph[k] = 0;
        end else if (set) begin
            m_cnt[k] = (int'(init) < M) ? int'(init) : M - 1;
            m_ph[k]  = 0;
        end else if (en) begin
            m_ph[k] = m_ph[k] + 1;
            if (m_ph[k] == pres(k)) begin
                m_ph[k]   = 0;
                raw       = m_cnt[k] + (dir ? 1 : -1);
                m_wrap[k] = (raw < 0 || raw >= M) ? 1 : 0;
                m_cnt[k]  = (raw + M) % M;
                m_tick[k] = 1;
            end
        end
    endtask

    function automatic int pack4();
        return int'({bus_p4.count, bus_p4.tick, bus_p4.wrap});
    endfunction

    function automatic int pack1();
        return int'({bus_p1.count, bus_p1.tick, bus_p1.wrap});
    endfunction

    function automatic int expv(input int c, input int t, input int w);
        return c * 4 + t * 2 + w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got cnt=%0d tick=%0d wrap=%0d, want cnt=%0d tick=%0d wrap=%0d",
                     name, act / 4, (act / 2) % 2, act % 2, exp / 4, (exp / 2) % 2, exp % 2);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("model_p4", pack4(), expv(m_cnt[0], m_tick[0], m_wrap[0]));
        chk("model_p1", pack1(), expv(m_cnt[1], m_tick[1], m_wrap[1]));
    endtask

    task automatic drive(input int e, input int d, input int s, input int c, input int i);
        en = (e != 0); dir = (d != 0); set = (s != 0); clr = (c != 0); init = 4'(i);
    endtask

    // Called just after a rising edge; reset pulse lies wholly between two edges.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_p4", pack4(), 0);
        chk("async_rst_p1", pack1(), 0);
        #2 reset = 1'b1;
    endtask

    typedef struct {
        int en, dir, set, clr, init;
        int cnt, tick, wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int e, input int d, input int s, input int c, input int i,
                       input int cn, input int t, input int w);
        vec_t v;
        v.en = e; v.dir = d; v.set = s; v.clr = c; v.init = i;
        v.cnt = cn; v.tick = t; v.wrap = w;
        vecs.push_back(v);
    endtask

    initial begin
        // Vectors for the PRESCALE=4 instance, starting from reset.
        add(1,1,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0);
        add(1,1,0,0,0, 1,1,0);
        add(1,1,0,0,0, 1,0,0); add(1,1,0,0,0, 1,0,0);
        add(1,1,1,0,7, 7,0,0);
        add(1,1,0,0,0, 7,0,0); add(1,1,0,0,0, 7,0,0); add(1,1,0,0,0, 7,0,0);
        add(1,1,0,0,0, 8,1,0);
        add(1,1,1,0,12, 9,0,0);
        add(1,1,0,0,0, 9,0,0); add(1,1,0,0,0, 9,0,0); add(1,1,0,0,0, 9,0,0);
        add(1,1,0,0,0, 0,1,1);
        add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 0,0,0); add(1,0,0,0,0, 0,0,0);
        add(1,0,0,0,0, 9,1,1);
        add(1,0,0,0,0, 9,0,0); add(1,0,0,0,0, 9,0,0); add(1,0,0,0,0, 9,0,0);
        add(1,0,1,1,3, 0,0,0);
        add(1,1,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0);
        add(0,1,0,0,0, 0,0,0); add(0,1,0,0,0, 0,0,0); add(0,1,0,0,0, 0,0,0);
        add(1,1,0,0,0, 0,0,0);
        add(1,1,0,0,0, 1,1,0);
        add(0,1,1,0,5, 5,0,0);
        add(0,1,0,1,0, 0,0,0);

        reset = 1'b0;
        drive(0, 1, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_p4", pack4(), 0);
        chk("reset_p1", pack1(), 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].dir, vecs[i].set, vecs[i].clr, vecs[i].init);
            cycle();
            chk($sformatf("vec%0d", i), pack4(), expv(vecs[i].cnt, vecs[i].tick, vecs[i].wrap));
        end

        // Free-running up count from reset: step every 4th edge, wrap on the 40th.
        reset_pulse();
        drive(1, 1, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            cycle();
            chk("run_p4", pack4(), expv((k / 4) % M, (k % 4 == 0) ? 1 : 0, (k == 40) ? 1 : 0));
            chk("run_p1", pack1(), expv(k % M, 1, (k % M == 0) ? 1 : 0));
        end

        // Reset mid-period at count 5 discards the two elapsed prescaler cycles.
        repeat (22) cycle();
        chk("at_five", pack4(), expv(5, 0, 0));
        reset_pulse();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("after_rst", pack4(), (k == 4) ? expv(1, 1, 0) : 0);
        end

        for (int n = 0; n < 1500; n++) begin
            en   = ($urandom_range(0, 9) < 8);
            set  = ($urandom_range(0, 19) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            init = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            cycle();
            if ($urandom_range(0, 199) == 0) reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
